// File: rtl/cla_adder_pipelined.sv
// Two-stage pipelined carry-lookahead adder/subtractor with valid/ready handshakes.
// Stage 1 registers operands and group generate/propagate; stage 2 resolves carries and flags.
module cla_adder_pipelined #(
    parameter int WIDTH = 16,
    parameter int GROUP = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] X,
    input  logic [WIDTH-1:0] Y,
    input  logic             Cin,
    input  logic             SUB,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] S,
    output logic             Cout,
    output logic             Ovf,
    output logic             Zero
);

    localparam int NGRP = WIDTH / GROUP;
    localparam int MAXN = (GROUP > NGRP) ? GROUP : NGRP;

    // Flattened sum-of-products carry into position n: no term depends on another carry.
    function automatic logic lookahead(input logic cin, input logic [MAXN-1:0] g,
                                       input logic [MAXN-1:0] p, input int n);
        logic res;
        logic term;
        res = 1'b0;
        for (int j = 0; j < MAXN; j++) begin
            if (j < n) begin
                term = g[j];
                for (int k = j + 1; k < MAXN; k++) begin
                    if (k < n) term = term & p[k];
                end
                res = res | term;
            end
        end
        term = cin;
        for (int k = 0; k < MAXN; k++) begin
            if (k < n) term = term & p[k];
        end
        return res | term;
    endfunction

    logic             w_s1Adv;
    logic             w_s2Load;
    logic [WIDTH-1:0] w_yEff;
    logic             w_c0;
    logic [WIDTH-1:0] w_g;
    logic [WIDTH-1:0] w_p;
    logic [NGRP-1:0]  w_grpG;
    logic [NGRP-1:0]  w_grpP;

    logic             r_s1Valid;
    logic [WIDTH-2:0] r_s1X;
    logic [WIDTH-2:0] r_s1Y;
    logic             r_s1SignX;
    logic             r_s1SignY;
    logic             r_s1C0;
    logic [NGRP-1:0]  r_s1G;
    logic [NGRP-1:0]  r_s1P;

    logic [WIDTH-1:0] w_gb;
    logic [WIDTH-1:0] w_pb;
    logic [NGRP-1:0]  w_cg;
    logic [WIDTH-1:0] w_c;
    logic             w_cout;
    logic [WIDTH-1:0] w_sum;

    logic             r_s2Valid;
    logic [WIDTH-1:0] r_s2Sum;
    logic             r_s2Cout;
    logic             r_s2Ovf;
    logic             r_s2Zero;

    assign w_s2Load = !r_s2Valid || out_ready;
    assign w_s1Adv  = !r_s1Valid || w_s2Load;
    assign in_ready = w_s1Adv;

    // Subtraction is X + ~Y + 1, so Cin is overridden by the forced carry-in.
    assign w_yEff = SUB ? ~Y : Y;
    assign w_c0   = SUB | Cin;
    assign w_g    = X & w_yEff;
    assign w_p    = X ^ w_yEff;

    always_comb begin
        logic [MAXN-1:0] gv;
        logic [MAXN-1:0] pv;
        w_grpG = '0;
        w_grpP = '0;
        for (int k = 0; k < NGRP; k++) begin
            gv = '0;
            pv = '0;
            gv[GROUP-1:0] = w_g[k*GROUP +: GROUP];
            pv[GROUP-1:0] = w_p[k*GROUP +: GROUP];
            w_grpG[k] = lookahead(1'b0, gv, pv, GROUP);
            w_grpP[k] = &w_p[k*GROUP +: GROUP];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1Valid <= 1'b0;
            r_s1X     <= '0;
            r_s1Y     <= '0;
            r_s1SignX <= 1'b0;
            r_s1SignY <= 1'b0;
            r_s1C0    <= 1'b0;
            r_s1G     <= '0;
            r_s1P     <= '0;
        end else if (w_s1Adv) begin
            r_s1Valid <= in_valid;
            if (in_valid) begin
                r_s1X     <= X[WIDTH-2:0];
                r_s1Y     <= w_yEff[WIDTH-2:0];
                r_s1SignX <= X[WIDTH-1];
                r_s1SignY <= w_yEff[WIDTH-1];
                r_s1C0    <= w_c0;
                r_s1G     <= w_grpG;
                r_s1P     <= w_grpP;
            end
        end
    end

    assign w_gb = {r_s1SignX & r_s1SignY, r_s1X & r_s1Y};
    assign w_pb = {r_s1SignX ^ r_s1SignY, r_s1X ^ r_s1Y};

    // Second-level lookahead gives every group carry-in directly from c0 and group G/P.
    always_comb begin
        logic [MAXN-1:0] grpG;
        logic [MAXN-1:0] grpP;
        logic [MAXN-1:0] gv;
        logic [MAXN-1:0] pv;
        grpG = '0;
        grpP = '0;
        grpG[NGRP-1:0] = r_s1G;
        grpP[NGRP-1:0] = r_s1P;
        w_cg = '0;
        w_c  = '0;
        for (int k = 0; k < NGRP; k++) begin
            w_cg[k] = lookahead(r_s1C0, grpG, grpP, k);
        end
        w_cout = lookahead(r_s1C0, grpG, grpP, NGRP);
        for (int k = 0; k < NGRP; k++) begin
            gv = '0;
            pv = '0;
            gv[GROUP-1:0] = w_gb[k*GROUP +: GROUP];
            pv[GROUP-1:0] = w_pb[k*GROUP +: GROUP];
            for (int j = 0; j < GROUP; j++) begin
                w_c[k*GROUP + j] = lookahead(w_cg[k], gv, pv, j);
            end
        end
    end

    assign w_sum = w_pb ^ w_c;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s2Valid <= 1'b0;
            r_s2Sum   <= '0;
            r_s2Cout  <= 1'b0;
            r_s2Ovf   <= 1'b0;
            r_s2Zero  <= 1'b0;
        end else if (w_s2Load) begin
            r_s2Valid <= r_s1Valid;
            if (r_s1Valid) begin
                r_s2Sum  <= w_sum;
                r_s2Cout <= w_cout;
                r_s2Ovf  <= w_c[WIDTH-1] ^ w_cout;
                r_s2Zero <= ~|w_sum;
            end
        end
    end

    assign out_valid = r_s2Valid;
    assign S         = r_s2Sum;
    assign Cout      = r_s2Cout;
    assign Ovf       = r_s2Ovf;
    assign Zero      = r_s2Zero;

endmodule

// File: tb/tb_cla_adder_pipelined.sv
// Bench for cla_adder_pipelined: 8/16/32-bit instances in lockstep, scored against an
// arithmetic reference model, plus literal vectors, backpressure and mid-flight reset.
module tb_cla_adder_pipelined;

    typedef struct {
        logic [31:0] s;
        logic        c;
        logic        o;
        logic        z;
        int          cyc;
        bit          free;
        bit          hasLit;
        logic [18:0] lit;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b1;
    logic        Cin = 1'b0;
    logic        SUB = 1'b0;
    logic [31:0] tbX = '0;
    logic [31:0] tbY = '0;
    bit          tbFreeFlow = 1'b0;
    bit          tbHasLit = 1'b0;
    logic [18:0] tbLit = '0;

    logic        inReady8, inReady16, inReady32;
    logic        outValid8, outValid16, outValid32;
    logic [7:0]  s8;
    logic [15:0] s16;
    logic [31:0] s32;
    logic        cout8, cout16, cout32;
    logic        ovf8, ovf16, ovf32;
    logic        zero8, zero16, zero32;

    int   checks = 0;
    int   errors = 0;
    int   cycle = 0;
    exp_t q8[$];
    exp_t q16[$];
    exp_t q32[$];

    always #5 clk = ~clk;

    cla_adder_pipelined #(.WIDTH(16), .GROUP(4)) dut16 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(inReady16),
        .X(tbX[15:0]), .Y(tbY[15:0]), .Cin(Cin), .SUB(SUB),
        .out_valid(outValid16), .out_ready(out_ready),
        .S(s16), .Cout(cout16), .Ovf(ovf16), .Zero(zero16)
    );

    cla_adder_pipelined #(.WIDTH(8), .GROUP(4)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(inReady8),
        .X(tbX[7:0]), .Y(tbY[7:0]), .Cin(Cin), .SUB(SUB),
        .out_valid(outValid8), .out_ready(out_ready),
        .S(s8), .Cout(cout8), .Ovf(ovf8), .Zero(zero8)
    );

    cla_adder_pipelined #(.WIDTH(32), .GROUP(8)) dut32 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(inReady32),
        .X(tbX), .Y(tbY), .Cin(Cin), .SUB(SUB),
        .out_valid(outValid32), .out_ready(out_ready),
        .S(s32), .Cout(cout32), .Ovf(ovf32), .Zero(zero32)
    );

    // Reference: unsigned sum for S/Cout, signed range test for Ovf.
    function automatic exp_t model(input logic [31:0] x, input logic [31:0] y,
                                   input logic cin, input logic sub, input int w);
        exp_t   e;
        longint mask, half, xu, yu, sx, sy, full, rs;
        logic [63:0] sumBits;
        mask = (longint'(1) <<< w) - 1;
        half = longint'(1) <<< (w - 1);
        xu = longint'(x) & mask;
        yu = longint'(y) & mask;
        sx = (xu >= half) ? xu - 2 * half : xu;
        sy = (yu >= half) ? yu - 2 * half : yu;
        if (sub) begin
            full = xu - yu;
            e.c  = (xu >= yu);
            rs   = sx - sy;
        end else begin
            full = xu + yu + longint'(cin);
            e.c  = (full > mask);
            rs   = sx + sy + longint'(cin);
        end
        sumBits  = 64'(full & mask);
        e.s      = sumBits[31:0];
        e.o      = (rs >= half) || (rs < -half);
        e.z      = (e.s == 32'd0);
        e.cyc    = 0;
        e.free   = 1'b0;
        e.hasLit = 1'b0;
        e.lit    = '0;
        return e;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic flagUnexpected(input string name);
        checks++;
        errors++;
        $display("[TB] FAIL %s: out_valid=1 with no beat outstanding, expected 0", name);
    endtask

    // Single compare process: record accepted beats, score every delivered result.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            cycle++;
            if (in_valid && inReady16) begin
                e = model(tbX, tbY, Cin, SUB, 16);
                e.cyc = cycle; e.free = tbFreeFlow; e.hasLit = tbHasLit; e.lit = tbLit;
                q16.push_back(e);
            end
            if (in_valid && inReady8) begin
                e = model(tbX, tbY, Cin, SUB, 8);
                q8.push_back(e);
            end
            if (in_valid && inReady32) begin
                e = model(tbX, tbY, Cin, SUB, 32);
                q32.push_back(e);
            end
            if (outValid16 && out_ready) begin
                if (q16.size() == 0) flagUnexpected("dut16");
                else begin
                    e = q16.pop_front();
                    checkOutput("dut16 result", {cout16, ovf16, zero16, 16'h0, s16}, {e.c, e.o, e.z, e.s});
                    if (e.hasLit)
                        checkOutput("dut16 literal", {cout16, ovf16, zero16, s16}, e.lit);
                    if (e.free && tbFreeFlow)
                        checkOutput("dut16 latency", cycle - e.cyc, 2);
                end
            end
            if (outValid8 && out_ready) begin
                if (q8.size() == 0) flagUnexpected("dut8");
                else begin
                    e = q8.pop_front();
                    checkOutput("dut8 result", {cout8, ovf8, zero8, 24'h0, s8}, {e.c, e.o, e.z, e.s});
                end
            end
            if (outValid32 && out_ready) begin
                if (q32.size() == 0) flagUnexpected("dut32");
                else begin
                    e = q32.pop_front();
                    checkOutput("dut32 result", {cout32, ovf32, zero32, s32}, {e.c, e.o, e.z, e.s});
                end
            end
        end
    end

    // Presents one beat from posedge+1 and holds it until it transfers.
    task automatic applyStimulus(input logic [31:0] x, input logic [31:0] y, input logic cin,
                                 input logic sub, input bit hasLit, input logic [18:0] lit);
        int   waits;
        bit   rdy;
        exp_t m;
        tbX = x; tbY = y; Cin = cin; SUB = sub;
        tbHasLit = hasLit; tbLit = lit; in_valid = 1'b1;
        if (hasLit) begin
            m = model(x, y, cin, sub, 16);
            checkOutput("model pin", {m.c, m.o, m.z, m.s[15:0]}, lit);
        end
        waits = 0;
        rdy = 1'b0;
        while (!rdy && waits < 50) begin
            @(negedge clk);
            rdy = inReady16;
            if (!rdy) begin
                @(posedge clk); #1;
                waits++;
            end
        end
        if (!rdy) begin
            checks++;
            errors++;
            $display("[TB] FAIL in_ready timeout: got 0 for %0d cycles, expected 1", waits);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        tbHasLit = 1'b0;
    endtask

    logic [31:0] bpX[4] = '{32'h0000_0010, 32'h0000_7FFF, 32'h0000_1234, 32'h0000_FFFF};
    logic [31:0] bpY[4] = '{32'h0000_0020, 32'h0000_0002, 32'h0000_1234, 32'h0000_0001};

    initial begin
        bit   rdySeq[4];
        bit   acc;
        int   idx;

        // Reset with a beat offered: nothing may be captured.
        #1 rst_n = 1'b0;
        in_valid = 1'b1; tbX = 32'h1111_1111; tbY = 32'h2222_2222;
        #2;
        checkOutput("reset out_valid", outValid16, 0);
        checkOutput("reset S", s16, 0);
        checkOutput("reset Cout", cout16, 0);
        checkOutput("reset Ovf", ovf16, 0);
        checkOutput("reset Zero", zero16, 0);
        checkOutput("reset in_ready", inReady16, 1);
        repeat (3) @(posedge clk);
        #1 checkOutput("reset hold out_valid", outValid16, 0);
        in_valid = 1'b0;
        #2 rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1 checkOutput("post-reset no capture", outValid16, 0);

        // Eight literal vectors back-to-back, free-flowing output.
        tbFreeFlow = 1'b1;
        applyStimulus(32'hFFFF, 32'h0001, 1'b0, 1'b0, 1'b1, {1'b1, 1'b0, 1'b1, 16'h0000});
        applyStimulus(32'h7FFF, 32'h0001, 1'b0, 1'b0, 1'b1, {1'b0, 1'b1, 1'b0, 16'h8000});
        applyStimulus(32'h0005, 32'h0007, 1'b1, 1'b1, 1'b1, {1'b0, 1'b0, 1'b0, 16'hFFFE});
        applyStimulus(32'h8000, 32'h0001, 1'b0, 1'b1, 1'b1, {1'b1, 1'b1, 1'b0, 16'h7FFF});
        applyStimulus(32'h1234, 32'h4321, 1'b1, 1'b0, 1'b1, {1'b0, 1'b0, 1'b0, 16'h5556});
        applyStimulus(32'h00AA, 32'h00AA, 1'b0, 1'b1, 1'b1, {1'b1, 1'b0, 1'b1, 16'h0000});
        applyStimulus(32'h8000, 32'h8000, 1'b0, 1'b0, 1'b1, {1'b1, 1'b1, 1'b1, 16'h0000});
        applyStimulus(32'hFFFF, 32'hFFFF, 1'b1, 1'b0, 1'b1, {1'b1, 1'b0, 1'b0, 16'hFFFF});
        repeat (4) @(posedge clk);
        #1 tbFreeFlow = 1'b0;
        checkOutput("directed drained", q16.size(), 0);

        // Backpressure: two beats fill the pipe, then in_ready must drop.
        out_ready = 1'b0;
        idx = 0;
        tbX = bpX[0]; tbY = bpY[0]; Cin = 1'b0; SUB = 1'b0; in_valid = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            rdySeq[c] = inReady16;
            acc = in_valid && inReady16;
            @(posedge clk); #1;
            if (acc) begin
                idx++;
                tbX = bpX[idx]; tbY = bpY[idx];
            end
        end
        checkOutput("stall ready c0", rdySeq[0], 1);
        checkOutput("stall ready c1", rdySeq[1], 1);
        checkOutput("stall ready c2", rdySeq[2], 0);
        checkOutput("stall ready c3", rdySeq[3], 0);
        checkOutput("stall accepted", idx, 2);
        out_ready = 1'b1;
        for (int c = 0; c < 20 && idx < 4; c++) begin
            @(negedge clk);
            acc = in_valid && inReady16;
            @(posedge clk); #1;
            if (acc) begin
                idx++;
                if (idx < 4) begin tbX = bpX[idx]; tbY = bpY[idx]; end
            end
        end
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1 checkOutput("stall drained", q16.size(), 0);

        // Asynchronous reset with two beats in flight.
        tbX = 32'h0000_0003; tbY = 32'h0000_0004; in_valid = 1'b1;
        @(negedge clk); @(posedge clk); #1;
        tbX = 32'h0000_0100; tbY = 32'h0000_0200;
        @(negedge clk); @(posedge clk); #1;
        in_valid = 1'b0;
        checkOutput("in-flight out_valid", outValid16, 1);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("async reset out_valid", outValid16, 0);
        checkOutput("async reset S", s16, 0);
        checkOutput("async reset Cout", cout16, 0);
        checkOutput("async reset in_ready", inReady16, 1);
        checkOutput("async reset out_valid w8/w32", {outValid8, outValid32}, 0);
        q8.delete(); q16.delete(); q32.delete();
        @(posedge clk); #3 rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1 checkOutput("no stale result", outValid16, 0);

        // Random traffic with random backpressure across all three widths.
        acc = 1'b1;
        for (int c = 0; c < 800; c++) begin
            if (acc || !in_valid) begin
                tbX = $urandom; tbY = $urandom;
                if ($urandom_range(0, 7) == 0) tbY = ~tbX;
                if ($urandom_range(0, 7) == 0) tbX = 32'hFFFF_FFFF;
                Cin = 1'($urandom_range(0, 1));
                SUB = 1'($urandom_range(0, 1));
                in_valid = ($urandom_range(0, 9) < 7);
            end
            out_ready = ($urandom_range(0, 9) < 7);
            @(negedge clk);
            acc = in_valid && inReady16;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c < 30 && (q8.size() + q16.size() + q32.size()) != 0; c++)
            @(posedge clk);
        #1;
        checkOutput("final drain w16", q16.size(), 0);
        checkOutput("final drain w8", q8.size(), 0);
        checkOutput("final drain w32", q32.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
